// File: rtl/alarm_ui_pkg.sv
// Shared types and helpers for the alarm clock front-panel controller.
package alarm_ui_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ET_H = 3'd1,
    ET_M = 3'd2,
    EA_H = 3'd3,
    EA_M = 3'd4,
    LOAD = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HOUR = 2'd1,
    FIELD_MIN  = 2'd2
  } field_t;

  localparam int HOURS_PER_DAY = 24;
  localparam int MIN_PER_HOUR  = 60;

  function automatic logic [5:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] units);
    return ({2'b00, tens} * 6'd10) + {2'b00, units};
  endfunction

endpackage

// File: rtl/alarm_ui_controller_bcd_split.sv
// Combinational split of a binary value 0..59 into BCD tens and units digits.
module bcd_split #(
  parameter int TENS_W = 4
) (
  input  logic [5:0]        bin,
  output logic [TENS_W-1:0] tens,
  output logic [3:0]        units
);

  logic [3:0] tens_off;

  // Units use a 4-bit wrap-around subtraction of (tens*10 mod 16), exact for 0..59.
  always_comb begin
    if (bin >= 6'd50) begin
      tens = TENS_W'(3'd5); tens_off = 4'd2;
    end else if (bin >= 6'd40) begin
      tens = TENS_W'(3'd4); tens_off = 4'd8;
    end else if (bin >= 6'd30) begin
      tens = TENS_W'(3'd3); tens_off = 4'd14;
    end else if (bin >= 6'd20) begin
      tens = TENS_W'(3'd2); tens_off = 4'd4;
    end else if (bin >= 6'd10) begin
      tens = TENS_W'(3'd1); tens_off = 4'd10;
    end else begin
      tens = TENS_W'(3'd0); tens_off = 4'd0;
    end
    units = bin[3:0] - tens_off;
  end

endmodule

// File: rtl/alarm_ui_controller.sv
// Turns four front-panel buttons into time/alarm configuration strobes and digits
// for the clock core, with an edit buffer, a shadow alarm copy and snooze.
module alarm_ui_controller
  import alarm_ui_pkg::*;
#(
  parameter int LD_HOLD     = 12,
  parameter int TIMEOUT_CYC = 1000,
  parameter int SNOOZE_MIN  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_set,
  input  logic       Alarm,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [3:0] cur_M1,
  input  logic [3:0] cur_M0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_alarm,
  output logic       AL_ON,
  output logic [1:0] edit_field,
  output logic       edit_alarm
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int HW = $clog2(LD_HOLD + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LD_HOLD - 1);
  localparam logic [4:0]    HOUR_MAX  = 5'(HOURS_PER_DAY - 1);
  localparam logic [5:0]    MIN_MAX   = 6'(MIN_PER_HOUR - 1);
  localparam logic [5:0]    SNZ_ADD   = 6'(SNOOZE_MIN);
  localparam logic [5:0]    SNZ_WRAP  = 6'(MIN_PER_HOUR - SNOOZE_MIN);

  state_t        state_r, state_nxt;
  field_t        field_nxt;
  logic [3:0]    prev_r, rise_s;
  logic          ev_set_s, ev_mode_s, ev_up_s, ev_down_s;
  logic          is_hour_s, is_alarm_s;
  logic [4:0]    eb_hour_r, eb_hour_nxt, sh_hour_r, sh_hour_nxt;
  logic [5:0]    eb_min_r, eb_min_nxt, sh_min_r, sh_min_nxt;
  logic [4:0]    hour_inc_s, hour_dec_s, snz_hour_s;
  logic [5:0]    min_inc_s, min_dec_s, snz_min_s;
  logic [TW-1:0] to_cnt_r, to_cnt_nxt;
  logic [HW-1:0] hold_cnt_r, hold_cnt_nxt;
  logic          ld_time_nxt, ld_alarm_nxt, stop_nxt, al_on_nxt;
  logic [1:0]    hr_tens_s;
  logic [3:0]    hr_units_s, mn_tens_s, mn_units_s;

  // Rising edges, one acted on per cycle: set > mode > up > down.
  assign rise_s    = {btn_set, btn_mode, btn_up, btn_down} & ~prev_r;
  assign ev_set_s  = rise_s[3];
  assign ev_mode_s = rise_s[2] & ~rise_s[3];
  assign ev_up_s   = rise_s[1] & ~(|rise_s[3:2]);
  assign ev_down_s = rise_s[0] & ~(|rise_s[3:1]);

  assign is_hour_s  = (state_r == ET_H) || (state_r == EA_H);
  assign is_alarm_s = (state_r == EA_H) || (state_r == EA_M);
  assign hour_inc_s = (eb_hour_r == HOUR_MAX) ? 5'd0 : eb_hour_r + 5'd1;
  assign hour_dec_s = (eb_hour_r == 5'd0) ? HOUR_MAX : eb_hour_r - 5'd1;
  assign min_inc_s  = (eb_min_r == MIN_MAX) ? 6'd0 : eb_min_r + 6'd1;
  assign min_dec_s  = (eb_min_r == 6'd0) ? MIN_MAX : eb_min_r - 6'd1;

  // Snooze target: shadow alarm plus SNOOZE_MIN, carrying into the hour.
  always_comb begin
    if (sh_min_r >= SNZ_WRAP) begin
      snz_min_s  = sh_min_r - SNZ_WRAP;
      snz_hour_s = (sh_hour_r == HOUR_MAX) ? 5'd0 : sh_hour_r + 5'd1;
    end else begin
      snz_min_s  = sh_min_r + SNZ_ADD;
      snz_hour_s = sh_hour_r;
    end
  end

  // Next-state, buffer, strobe and counter logic.
  always_comb begin
    state_nxt    = state_r;
    eb_hour_nxt  = eb_hour_r;
    eb_min_nxt   = eb_min_r;
    sh_hour_nxt  = sh_hour_r;
    sh_min_nxt   = sh_min_r;
    ld_time_nxt  = LD_time;
    ld_alarm_nxt = LD_alarm;
    stop_nxt     = STOP_alarm;
    al_on_nxt    = AL_ON;
    to_cnt_nxt   = '0;
    hold_cnt_nxt = '0;
    case (state_r)
      IDLE: begin
        if (ev_set_s) begin
          if (Alarm) begin
            stop_nxt  = 1'b1;
            state_nxt = LOAD;
          end else begin
            al_on_nxt = ~AL_ON;
          end
        end else if (ev_mode_s) begin
          eb_hour_nxt = 5'(bcd_to_bin({2'b00, cur_H1}, cur_H0));
          eb_min_nxt  = bcd_to_bin(cur_M1, cur_M0);
          state_nxt   = ET_H;
        end else if ((ev_up_s || ev_down_s) && Alarm) begin
          sh_hour_nxt  = snz_hour_s;
          sh_min_nxt   = snz_min_s;
          eb_hour_nxt  = snz_hour_s;
          eb_min_nxt   = snz_min_s;
          stop_nxt     = 1'b1;
          ld_alarm_nxt = 1'b1;
          state_nxt    = LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      ET_H, ET_M, EA_H, EA_M: begin
        if (ev_set_s) begin
          state_nxt = LOAD;
          if (is_alarm_s) begin
            sh_hour_nxt  = eb_hour_r;
            sh_min_nxt   = eb_min_r;
            ld_alarm_nxt = 1'b1;
          end else begin
            ld_time_nxt = 1'b1;
          end
        end else if (ev_mode_s) begin
          case (state_r)
            ET_H: state_nxt = ET_M;
            ET_M: begin
              eb_hour_nxt = sh_hour_r;
              eb_min_nxt  = sh_min_r;
              state_nxt   = EA_H;
            end
            EA_H:    state_nxt = EA_M;
            default: state_nxt = IDLE;
          endcase
        end else if (ev_up_s) begin
          if (is_hour_s) eb_hour_nxt = hour_inc_s;
          else           eb_min_nxt  = min_inc_s;
        end else if (ev_down_s) begin
          if (is_hour_s) eb_hour_nxt = hour_dec_s;
          else           eb_min_nxt  = min_dec_s;
        end else if (to_cnt_r == TO_LAST) begin
          state_nxt = IDLE;
        end else begin
          to_cnt_nxt = to_cnt_r + TW'(1);
        end
      end
      LOAD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_nxt    = IDLE;
          ld_time_nxt  = 1'b0;
          ld_alarm_nxt = 1'b0;
          stop_nxt     = 1'b0;
        end else begin
          hold_cnt_nxt = hold_cnt_r + HW'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        ld_time_nxt  = 1'b0;
        ld_alarm_nxt = 1'b0;
        stop_nxt     = 1'b0;
      end
    endcase
  end

  // Blink field follows the state being entered so it lines up with the digits.
  always_comb begin
    case (state_nxt)
      ET_H, EA_H: field_nxt = FIELD_HOUR;
      ET_M, EA_M: field_nxt = FIELD_MIN;
      default:    field_nxt = FIELD_NONE;
    endcase
  end

  bcd_split #(.TENS_W(2)) u_split_hour (.bin({1'b0, eb_hour_nxt}), .tens(hr_tens_s), .units(hr_units_s));
  bcd_split #(.TENS_W(4)) u_split_min  (.bin(eb_min_nxt),          .tens(mn_tens_s), .units(mn_units_s));

  // State, buffers and all outputs are registered on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      prev_r     <= 4'd0;
      eb_hour_r  <= 5'd0;
      eb_min_r   <= 6'd0;
      sh_hour_r  <= 5'd0;
      sh_min_r   <= 6'd0;
      to_cnt_r   <= '0;
      hold_cnt_r <= '0;
      LD_time    <= 1'b0;
      LD_alarm   <= 1'b0;
      STOP_alarm <= 1'b0;
      AL_ON      <= 1'b0;
      edit_field <= 2'd0;
      edit_alarm <= 1'b0;
      H_in1      <= 2'd0;
      H_in0      <= 4'd0;
      M_in1      <= 4'd0;
      M_in0      <= 4'd0;
    end else begin
      state_r    <= state_nxt;
      prev_r     <= {btn_set, btn_mode, btn_up, btn_down};
      eb_hour_r  <= eb_hour_nxt;
      eb_min_r   <= eb_min_nxt;
      sh_hour_r  <= sh_hour_nxt;
      sh_min_r   <= sh_min_nxt;
      to_cnt_r   <= to_cnt_nxt;
      hold_cnt_r <= hold_cnt_nxt;
      LD_time    <= ld_time_nxt;
      LD_alarm   <= ld_alarm_nxt;
      STOP_alarm <= stop_nxt;
      AL_ON      <= al_on_nxt;
      edit_field <= field_nxt;
      edit_alarm <= (state_nxt == EA_H) || (state_nxt == EA_M);
      H_in1      <= hr_tens_s;
      H_in0      <= hr_units_s;
      M_in1      <= mn_tens_s;
      M_in0      <= mn_units_s;
    end
  end

endmodule
